// File: rtl/truth_table_checker.sv
`timescale 1ns/1ps
// truth_table_checker: sweeps all 2^N_IN input vectors onto N_CH parallel
// implementations of a combinational circuit. Each vector is held for
// SETTLE+1 cycles; on the last cycle edge the channel outputs are compared
// against a latched golden LUT (mode 0) or against channel 0 (mode 1).
// Per-channel error counts, a sticky fail mask and the first failing vector
// are accumulated over the sweep. dut_y only feeds registers, so there is no
// combinational path from the circuits under test to any output.
module truth_table_checker #(
   parameter int N_IN   = 3,
   parameter int N_CH   = 3,
   parameter int SETTLE = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     mode,
   input  logic [2**N_IN-1:0]       golden_lut,
   input  logic [N_CH-1:0]          dut_y,
   output logic [N_IN-1:0]          vec_out,
   output logic                     busy,
   output logic                     done,
   output logic                     pass,
   output logic                     sample_valid,
   output logic [N_IN-1:0]          sample_idx,
   output logic [N_CH-1:0]          sample_mismatch,
   output logic [N_CH-1:0]          fail_mask,
   output logic [N_CH*(N_IN+1)-1:0] err_count,
   output logic                     first_fail_valid,
   output logic [N_IN-1:0]          first_fail_idx
);

   localparam int NVEC = 1 << N_IN;
   localparam int CW   = N_IN + 1;
   // The hold counter needs at least one bit even when SETTLE is 0.
   localparam int HW   = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
   localparam logic [HW-1:0]   HOLD_MAX = HW'(SETTLE);
   localparam logic [N_IN-1:0] LAST_VEC = {N_IN{1'b1}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t              state;
   state_t              state_next;
   logic [HW-1:0]       hold_cnt;
   logic [NVEC-1:0]     lut_q;
   logic                mode_q;
   logic                sweep_start;
   logic                sample_edge;
   logic                last_vec;
   logic                lut_bit;
   logic [N_CH-1:0]     ref_bits;
   logic [N_CH-1:0]     mismatch;
   logic [N_CH*CW-1:0]  err_next;

   // busy and done are pure decodes of the registered state.
   assign busy = (state == S_RUN);
   assign done = (state == S_DONE);

   // State register; synchronous reset abandons any sweep in progress.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values of the others, independent of block order.
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   // Next-state decode plus the start / sample / last-vector event flags.
   always_comb begin
      // NOTE: every variable gets a default first, so no path through the case
      // leaves it unassigned and no latch is inferred.
      state_next  = state;
      sweep_start = 1'b0;
      sample_edge = 1'b0;
      last_vec    = 1'b0;
      case (state)
         S_IDLE, S_DONE: begin
            if (start) begin
               sweep_start = 1'b1;
               state_next  = S_RUN;
            end
         end
         S_RUN: begin
            // start is ignored here: a running sweep is never restarted.
            if (hold_cnt == HOLD_MAX) begin
               sample_edge = 1'b1;
               if (vec_out == LAST_VEC) begin
                  last_vec   = 1'b1;
                  state_next = S_DONE;
               end
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Reference selection and per-channel comparison for the current vector.
   always_comb begin
      lut_bit  = lut_q[vec_out];
      ref_bits = mode_q ? {N_CH{dut_y[0]}} : {N_CH{lut_bit}};
      // In mode 1 channel 0 is compared with itself and so never mismatches.
      mismatch = dut_y ^ ref_bits;
   end

   // Per-channel error counters incremented by this vector's mismatches;
   // CW bits hold the full 2^N_IN count, so no saturation is needed.
   always_comb begin
      err_next = err_count;
      for (int c = 0; c < N_CH; c++) begin
         err_next[c*CW +: CW] = err_count[c*CW +: CW] + CW'(mismatch[c]);
      end
   end

   // Sweep datapath: vector/hold counters, latched LUT, result accumulation
   // and the one-cycle sample strobe.
   always_ff @(posedge clk) begin
      if (reset) begin
         vec_out          <= '0;
         hold_cnt         <= '0;
         lut_q            <= '0;
         mode_q           <= 1'b0;
         pass             <= 1'b0;
         sample_valid     <= 1'b0;
         sample_idx       <= '0;
         sample_mismatch  <= '0;
         fail_mask        <= '0;
         err_count        <= '0;
         first_fail_valid <= 1'b0;
         first_fail_idx   <= '0;
      end else begin
         // Strobe reports the vector compared on the previous edge.
         sample_valid    <= sample_edge;
         sample_mismatch <= sample_edge ? mismatch : '0;
         if (sample_edge) sample_idx <= vec_out;

         if (sweep_start) begin
            // The LUT and mode are captured once; later input changes are
            // ignored until the next start.
            lut_q            <= golden_lut;
            mode_q           <= mode;
            vec_out          <= '0;
            hold_cnt         <= '0;
            pass             <= 1'b0;
            fail_mask        <= '0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
         end else if (state == S_RUN) begin
            if (sample_edge) begin
               hold_cnt  <= '0;
               // Natural wrap takes the last vector back to 0.
               vec_out   <= vec_out + N_IN'(1);
               err_count <= err_next;
               fail_mask <= fail_mask | mismatch;
               // Vectors ascend, so the first failure seen is the lowest index.
               if ((|mismatch) && !first_fail_valid) begin
                  first_fail_valid <= 1'b1;
                  first_fail_idx   <= vec_out;
               end
               if (last_vec) pass <= ((fail_mask | mismatch) == '0);
            end else begin
               hold_cnt <= hold_cnt + HW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_truth_table_checker.sv
`timescale 1ns/1ps
// Bench for truth_table_checker: two instances (N_IN=3/SETTLE=1 and
// N_IN=4/SETTLE=3) driven by a behavioural model of three circuit
// implementations. Expected strobes are queued when a sweep is launched and
// popped as the DUT reports them; final results come from the same model.
module tb_truth_table_checker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        mode;
   logic        start_a, start_b;
   logic [7:0]  lut_a;
   logic [15:0] lut_b;
   logic [2:0]  y_a, y_b;

   // Behaviour of the circuits under test (independent of golden_lut input).
   logic [15:0] circ_fn;
   bit          stuck1;
   bit          inv2;

   logic [2:0]  vec_a, sidx_a, ffi_a, smm_a, fm_a;
   logic        busy_a, done_a, pass_a, sv_a, ffv_a;
   logic [11:0] err_a;
   logic [3:0]  vec_b, sidx_b, ffi_b;
   logic [2:0]  smm_b, fm_b;
   logic        busy_b, done_b, pass_b, sv_b, ffv_b;
   logic [14:0] err_b;

   truth_table_checker #(.N_IN(3), .N_CH(3), .SETTLE(1)) u_dut_a (
      .clk(clk), .reset(reset), .start(start_a), .mode(mode),
      .golden_lut(lut_a), .dut_y(y_a), .vec_out(vec_a), .busy(busy_a),
      .done(done_a), .pass(pass_a), .sample_valid(sv_a), .sample_idx(sidx_a),
      .sample_mismatch(smm_a), .fail_mask(fm_a), .err_count(err_a),
      .first_fail_valid(ffv_a), .first_fail_idx(ffi_a)
   );

   truth_table_checker #(.N_IN(4), .N_CH(3), .SETTLE(3)) u_dut_b (
      .clk(clk), .reset(reset), .start(start_b), .mode(mode),
      .golden_lut(lut_b), .dut_y(y_b), .vec_out(vec_b), .busy(busy_b),
      .done(done_b), .pass(pass_b), .sample_valid(sv_b), .sample_idx(sidx_b),
      .sample_mismatch(smm_b), .fail_mask(fm_b), .err_count(err_b),
      .first_fail_valid(ffv_b), .first_fail_idx(ffi_b)
   );

   // Model of three implementations of circ_fn with optional planted faults.
   function automatic logic [2:0] model_y(input int k, input logic [15:0] fn,
                                          input bit s1, input bit i2);
      logic [2:0] y;
      y = {3{fn[k]}};
      if (s1) y[1] = 1'b0;
      if (i2 && k == 5) y[2] = ~y[2];
      return y;
   endfunction

   always_comb begin
      y_a = model_y(int'(vec_a), circ_fn, stuck1, inv2);
      y_b = model_y(int'(vec_b), circ_fn, stuck1, inv2);
   end

   // Observation mux: the active instance, widened to the larger geometry.
   bit         sel;
   logic [4:0] o_vec, o_sidx, o_ffi;
   logic [2:0] o_smm, o_fm;
   logic       o_busy, o_done, o_pass, o_sv, o_ffv;
   logic [4:0] o_err [3];

   always_comb begin
      o_vec  = sel ? {1'b0, vec_b}  : {2'b0, vec_a};
      o_sidx = sel ? {1'b0, sidx_b} : {2'b0, sidx_a};
      o_ffi  = sel ? {1'b0, ffi_b}  : {2'b0, ffi_a};
      o_smm  = sel ? smm_b  : smm_a;
      o_fm   = sel ? fm_b   : fm_a;
      o_busy = sel ? busy_b : busy_a;
      o_done = sel ? done_b : done_a;
      o_pass = sel ? pass_b : pass_a;
      o_sv   = sel ? sv_b   : sv_a;
      o_ffv  = sel ? ffv_b  : ffv_a;
      for (int c = 0; c < 3; c++)
         o_err[c] = sel ? err_b[c*5 +: 5] : {1'b0, err_a[c*4 +: 4]};
   end

   typedef struct packed {
      logic [4:0] idx;
      logic [2:0] mm;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_start(input bit use_b, input logic v);
      if (use_b) start_b = v;
      else       start_a = v;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " vec"},  o_vec,  0);
      check({tag, " busy"}, o_busy, 0);
      check({tag, " done"}, o_done, 0);
      check({tag, " pass"}, o_pass, 0);
      check({tag, " sv"},   o_sv,   0);
      check({tag, " sidx"}, o_sidx, 0);
      check({tag, " smm"},  o_smm,  0);
      check({tag, " fm"},   o_fm,   0);
      check({tag, " ffv"},  o_ffv,  0);
      check({tag, " ffi"},  o_ffi,  0);
      for (int c = 0; c < 3; c++)
         check($sformatf("%s err%0d", tag, c), o_err[c], 0);
   endtask

   // Runs one sweep. Caller must be at a falling edge. repulse_vec pulses
   // start and corrupts golden_lut while that vector is driven; abort_vec
   // asserts reset (with start) while that vector is driven and returns;
   // pulse_at_end pulses start on the edge where done rises.
   task automatic run_sweep(input bit use_b, input int nin, input int st,
                            input logic m, input logic [15:0] lut,
                            input int repulse_vec, input int abort_vec,
                            input bit pulse_at_end, input string name);
      int         total;
      int         e_err [3];
      logic [2:0] e_fm;
      bit         e_ffv;
      int         e_ffi;
      logic [2:0] y;
      logic [2:0] mm;
      exp_t       e;
      int         cur;
      bit         first;

      total = (1 << nin) * (st + 1);
      sel   = use_b;
      sb.delete();
      e_err = '{0, 0, 0};
      e_fm  = '0;
      e_ffv = 0;
      e_ffi = 0;
      for (int k = 0; k < (1 << nin); k++) begin
         y = model_y(k, circ_fn, stuck1, inv2);
         for (int c = 0; c < 3; c++)
            mm[c] = m ? (y[c] != y[0]) : (y[c] != lut[k]);
         sb.push_back('{idx: 5'(k), mm: mm});
         for (int c = 0; c < 3; c++) if (mm[c]) e_err[c]++;
         e_fm = e_fm | mm;
         if (mm != 3'b000 && !e_ffv) begin
            e_ffv = 1;
            e_ffi = k;
         end
      end

      mode = m;
      if (use_b) lut_b = lut;
      else       lut_a = lut[7:0];
      set_start(use_b, 1'b1);
      @(posedge clk);
      #1 set_start(use_b, 1'b0);
      @(negedge clk);
      check({name, " e0 vec"},  o_vec,  0);
      check({name, " e0 busy"}, o_busy, 1);
      check({name, " e0 done"}, o_done, 0);
      check({name, " e0 pass"}, o_pass, 0);
      check({name, " e0 fm"},   o_fm,   0);
      check({name, " e0 ffv"},  o_ffv,  0);
      for (int c = 0; c < 3; c++)
         check($sformatf("%s e0 err%0d", name, c), o_err[c], 0);

      for (int n = 1; n <= total; n++) begin
         cur   = (n - 1) / (st + 1);
         first = ((n - 1) % (st + 1)) == 0;
         if (cur == abort_vec && first) begin
            reset = 1'b1;
            set_start(use_b, 1'b1);
            @(posedge clk);
            #1;
            reset = 1'b0;
            set_start(use_b, 1'b0);
            @(negedge clk);
            check_all_zero({name, " abort"});
            sb.delete();
            return;
         end
         if (cur == repulse_vec && first) begin
            set_start(use_b, 1'b1);
            if (use_b) lut_b = ~lut;
            else       lut_a = ~lut[7:0];
         end
         if (pulse_at_end && n == total) set_start(use_b, 1'b1);
         @(posedge clk);
         #1 set_start(use_b, 1'b0);
         @(negedge clk);
         check($sformatf("%s vec n=%0d", name, n), o_vec,
               (n / (st + 1)) % (1 << nin));
         check($sformatf("%s sv n=%0d", name, n), o_sv,
               ((n % (st + 1)) == 0) ? 1 : 0);
         check($sformatf("%s busy n=%0d", name, n), o_busy, (n < total) ? 1 : 0);
         check($sformatf("%s done n=%0d", name, n), o_done, (n == total) ? 1 : 0);
         if (o_sv === 1'b1) begin
            if (sb.size() == 0) begin
               check($sformatf("%s extra strobe n=%0d", name, n), 1, 0);
            end else begin
               e = sb.pop_front();
               check($sformatf("%s sidx n=%0d", name, n), o_sidx, e.idx);
               check($sformatf("%s smm n=%0d", name, n), o_smm, e.mm);
            end
         end else begin
            check($sformatf("%s smm idle n=%0d", name, n), o_smm, 0);
         end
      end

      check({name, " sb empty"}, sb.size(), 0);
      check({name, " pass"}, o_pass, (e_fm == 3'b000) ? 1 : 0);
      check({name, " fm"},   o_fm,   e_fm);
      check({name, " ffv"},  o_ffv,  e_ffv);
      if (e_ffv) check({name, " ffi"}, o_ffi, e_ffi);
      for (int c = 0; c < 3; c++)
         check($sformatf("%s err%0d", name, c), o_err[c], e_err[c]);

      if (pulse_at_end) begin
         @(negedge clk);
         check({name, " hold done"}, o_done, 1);
         check({name, " hold busy"}, o_busy, 0);
         check({name, " hold vec"},  o_vec,  0);
         check({name, " hold sv"},   o_sv,   0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      reset   = 1'b1;
      start_a = 1'b0;
      start_b = 1'b0;
      mode    = 1'b0;
      lut_a   = '0;
      lut_b   = '0;
      circ_fn = '0;
      stuck1  = 0;
      inv2    = 0;
      sel     = 0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_all_zero("reset a");
      check("reset b busy", busy_b, 0);
      check("reset b done", done_b, 0);
      check("reset b err",  err_b,  0);

      // Correct implementations of 8'hE2.
      circ_fn = 16'h00E2;
      run_sweep(0, 3, 1, 1'b0, 16'h00E2, -1, -1, 0, "a_ok");

      // Channel 1 stuck at 0: fails where f=1 (vectors 1,5,6,7).
      stuck1 = 1;
      run_sweep(0, 3, 1, 1'b0, 16'h00E2, -1, -1, 0, "a_stuck1");
      check("a_stuck1 const err1", o_err[1], 4);
      check("a_stuck1 const fm",   o_fm,     3'b010);
      check("a_stuck1 const ffi",  o_ffi,    1);

      // Equivalence mode, channel 2 inverted only at vector 5.
      stuck1 = 0;
      inv2   = 1;
      run_sweep(0, 3, 1, 1'b1, 16'h00E2, -1, -1, 0, "a_equiv");
      check("a_equiv const err2", o_err[2], 1);
      check("a_equiv const ffi",  o_ffi,    5);
      check("a_equiv const pass", o_pass,   0);

      // Start re-pulsed and golden_lut corrupted at vector 3; start also
      // pulsed on the done edge.
      inv2 = 0;
      run_sweep(0, 3, 1, 1'b0, 16'h00E2, 3, -1, 1, "a_repulse");
      check("a_repulse const pass", o_pass, 1);

      // Reset (with start) while vector 4 is driven, then a clean sweep.
      stuck1 = 1;
      run_sweep(0, 3, 1, 1'b0, 16'h00E2, -1, 4, 0, "a_abort");
      stuck1 = 0;
      run_sweep(0, 3, 1, 1'b0, 16'h00E2, -1, -1, 0, "a_after_abort");

      // Wider instance, back-to-back sweeps.
      circ_fn = 16'h6A9C;
      run_sweep(1, 4, 3, 1'b0, 16'h6A9C, -1, -1, 0, "b_first");
      run_sweep(1, 4, 3, 1'b0, 16'h6A9C, -1, -1, 0, "b_second");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/truth_table_checker.md
Name: truth_table_checker

Overview:
Parametrised hardware truth-table sweeper and checker for combinational lab circuits. On start, a counter drives every one of the 2^N_IN input vectors onto the circuit(s) under test. After a settle window it samples N_CH implementation outputs and compares each one against a golden LUT (mode 0) or against channel 0 (mode 1, equivalence of gate-level and operator-level versions). It accumulates per-channel mismatch counts and first-failure info, replacing per-exercise hand-timed stimulus blocks.

Parameters:
N_IN, 3, number of circuit inputs; sweep length 2^N_IN vectors (1..8)
N_CH, 3, number of implementations checked in parallel (1..8)
SETTLE, 1, extra hold cycles per vector before sampling (>=0)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
start  input  1  begin sweep; honoured only when not busy
mode  input  1  0 = compare to golden_lut, 1 = compare each channel to channel 0
golden_lut  input  2^N_IN  expected output, bit k = f(vector k)
dut_y  input  N_CH  outputs of implementations, bit c = channel c
vec_out  output  N_IN  current input vector driven to all channels
busy  output  1  sweep in progress
done  output  1  sweep complete (level, held until next start or reset)
pass  output  1  valid when done; 1 if no channel mismatched
sample_valid  output  1  one-cycle strobe per compared vector
sample_idx  output  N_IN  vector index of the current strobe
sample_mismatch  output  N_CH  per-channel mismatch for the current strobe
fail_mask  output  N_CH  sticky OR of all mismatches this sweep
err_count  output  N_CH*(N_IN+1)  per-channel mismatch count, channel c at [c*(N_IN+1) +: N_IN+1]
first_fail_valid  output  1  at least one mismatch seen this sweep
first_fail_idx  output  N_IN  lowest vector index with any mismatch

Behaviour:
- Reset (sync, priority over everything): all outputs 0; state IDLE; hold counter 0. Applies equally mid-sweep; the sweep is abandoned.
- States: IDLE -> RUN on start; RUN -> DONE after the last vector is sampled; DONE -> RUN on start. DONE is left only by start or reset.
- Start edge E0 (IDLE or DONE):
  - latch golden_lut and mode into internal copies; later changes are ignored until the next start.
  - clear err_count, fail_mask, first_fail_*, done and pass.
  - set vec_out=0 and busy=1.
- start while busy is ignored.
- Vector k is driven from edge E0+k*(SETTLE+1) and held for SETTLE+1 cycles.
- Sampling happens on edge E0+(k+1)*(SETTLE+1), using dut_y as present before that edge. On the same edge vec_out advances to k+1.
- Compare on each sample edge:
  - mode 0: mismatch[c] = dut_y[c] != lut[k].
  - mode 1: mismatch[c] = dut_y[c] != dut_y[0]; mismatch[0] is always 0.
- Updates on the sample edge:
  - err_count[c] += mismatch[c]. Width N_IN+1 holds the 2^N_IN maximum, so no saturation or wrap is needed.
  - fail_mask |= mismatch.
  - If mismatch is nonzero and first_fail_valid=0: first_fail_idx=k and first_fail_valid=1.
- Strobe: in the cycle after each sample edge, sample_valid=1, sample_idx=k, sample_mismatch=mismatch. Otherwise sample_valid=0 and sample_mismatch=0.
- Last vector (k=2^N_IN-1), on its sample edge:
  - vec_out wraps to 0, busy=0, done=1, pass=(fail_mask_next==0).
  - Its sample_valid strobe coincides with the first done cycle.
- Total sweep time: done rises 2^N_IN*(SETTLE+1) cycles after E0.
- Simultaneous start and reset: reset wins.
- start in the same cycle that done rises: not busy in the following cycle, so it is honoured next cycle; the start sampled on the done edge itself is ignored (busy was 1).
- Counters, comparators and the LUT index are purely registered and parameter-sized. No combinational path from dut_y to any output.

Test Plan:
- N_IN=3, N_CH=3, SETTLE=1, mode 0, golden 8'hE2, all channels modelled correctly -> vec_out steps 0..7 every 2 cycles; done 16 cycles after start; pass=1; err_count all 0; eight sample_valid strobes with idx 0..7.
- Same setup, channel 1 stuck at 0 -> err_count ch1=4 (idx 1,5,6,7); ch0 and ch2 =0; fail_mask=3'b010; first_fail_idx=1; pass=0.
- mode 1, channel 2 inverted only at vector 5 -> err_count = {1,0,0}; sample_mismatch=3'b100 only at idx 5; first_fail_idx=5; pass=0.
- start re-pulsed at vector 3 plus golden_lut changed mid-sweep -> no restart, timing unchanged, results match the originally latched LUT.
- reset asserted while vec_out=4 -> next cycle all outputs 0, state IDLE; a new start sweeps again from vector 0 with counts cleared.
- N_IN=4, SETTLE=3, correct DUT -> each vector held 4 cycles; done at 64 cycles; vec_out wraps 15->0; a second start immediately after done repeats with identical results.
